// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: field widths, FSM encoding
// and the built-in song image used when no other ROM contents are supplied.
package song_pkg;

  localparam int NOTE_W              = 6;
  localparam int DUR_W               = 6;
  localparam int ROM_W               = NOTE_W + DUR_W;
  localparam int NOTES_PER_SONG_DEF  = 32;
  localparam int NUM_SONGS           = 4;
  localparam int ROM_DEPTH           = NOTES_PER_SONG_DEF * NUM_SONGS;
  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    LOAD,
    PLAYING,
    ADVANCE,
    END
  } state_e;

  // Fallback melody: every entry playable, so each song runs its full length.
  function automatic logic [ROM_DEPTH*ROM_W-1:0] default_song_image();
    logic [ROM_DEPTH*ROM_W-1:0] img;
    logic [NOTE_W-1:0]          n;
    logic [DUR_W-1:0]           d;
    img = '0;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      n = NOTE_W'((i * 5 + 3) % 64);
      d = DUR_W'(6 + (i % 4) * 6);
      img[i*ROM_W +: ROM_W] = {n, d};
    end
    return img;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song storage: one {note, duration} word per entry, synchronous read with one
// cycle of latency. Contents come from the INIT image parameter.
module song_rom
  import song_pkg::*;
#(
  parameter int                       DEPTH  = ROM_DEPTH,
  parameter int                       ADDR_W = $clog2(DEPTH),
  parameter logic [DEPTH*ROM_W-1:0]   INIT   = default_song_image()
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROM_W-1:0]  dout
);

  logic [ROM_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    dout_q <= INIT[addr*ROM_W +: ROM_W];
  end

  assign dout = dout_q;

endmodule

// File: rtl/song_reader.sv
// Sequencer that walks the selected song in song_rom and hands {note, duration}
// pairs to note_player. Define SONG_READER_LOOP_EN to repeat songs endlessly.
module song_reader
  import song_pkg::*;
#(
  parameter int NOTES_PER_SONG = NOTES_PER_SONG_DEF,
  parameter int SONG_SEL_W     = 2,
  parameter logic [(NOTES_PER_SONG << SONG_SEL_W)*ROM_W-1:0] ROM_INIT = default_song_image()
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play,
  input  logic [SONG_SEL_W-1:0]             song,
  input  logic                              done_with_note,
  output logic [NOTE_W-1:0]                 note_to_load,
  output logic [DUR_W-1:0]                  duration_to_load,
  output logic                              load_new_note,
  output logic                              song_done,
  output logic [$clog2(NOTES_PER_SONG)-1:0] note_idx
);

  localparam int IDX_W  = $clog2(NOTES_PER_SONG);
  localparam int DEPTH  = NOTES_PER_SONG << SONG_SEL_W;
  localparam int ADDR_W = SONG_SEL_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SONG_SEL_W-1:0]   song_q;
  logic [NOTE_W-1:0]       note_q;
  logic [DUR_W-1:0]        dur_q;
  logic                    load_q;
  logic                    done_q;
  logic                    pend_q;
  logic [ROM_W-1:0]        rom_dout;
  logic [DUR_W-1:0]        rom_dur;
  logic [ADDR_W-1:0]       rom_addr;

  assign rom_addr = {song_q, idx_q};
  assign rom_dur  = rom_dout[DUR_W-1:0];

  song_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INIT   (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      song_q  <= song;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      // A new selection restarts from entry 0; refetching drops any read in flight.
      if (song != song_q) begin
        song_q  <= song;
        idx_q   <= '0;
        pend_q  <= 1'b0;
        state_q <= play ? FETCH : IDLE;
      end else begin
        case (state_q)
          IDLE:     if (play) state_q <= FETCH;
          FETCH:    if (play) state_q <= WAIT_ROM;
          WAIT_ROM: if (play) begin
            note_q  <= rom_dout[ROM_W-1 -: NOTE_W];
            dur_q   <= rom_dur;
            load_q  <= (rom_dur != '0);
            done_q  <= (rom_dur == '0);
            state_q <= LOAD;
          end
          LOAD:     if (play) state_q <= (dur_q == '0) ? END : PLAYING;
          PLAYING: begin
            // Note ends seen while paused are remembered until play resumes.
            if (!play) begin
              if (done_with_note) pend_q <= 1'b1;
            end else if (done_with_note || pend_q) begin
              pend_q  <= 1'b0;
              state_q <= ADVANCE;
            end
          end
          ADVANCE:  if (play) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= END;
            end else begin
              state_q <= FETCH;
            end
          end
          END: begin
`ifdef SONG_READER_LOOP_EN
            if (play) begin
              idx_q   <= '0;
              state_q <= FETCH;
            end
`else
            if (!play) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end
`endif
          end
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;
  assign note_idx         = idx_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: random note gaps and pauses checked against an
// entry-level model of the song walk. Honours SONG_READER_LOOP_EN like the DUT.
module tb_song_reader;

  localparam int N_ENT = 128;

  function automatic logic [N_ENT*12-1:0] tb_image();
    logic [N_ENT*12-1:0] img;
    logic [31:0]         h;
    logic [5:0]          n;
    logic [5:0]          d;
    img = '0;
    for (int i = 0; i < N_ENT; i++) begin
      h = 32'(i + 1) * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      n = h[11:6];
      d = {1'b0, h[20:16]} + 6'd1;
      if (i == 0) begin
        n = 6'd20;
        d = 6'd5;
      end
      if (i == 35) d = 6'd0;
      img[i*12 +: 12] = {n, d};
    end
    return img;
  endfunction

  localparam logic [N_ENT*12-1:0] TB_IMG = tb_image();

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic [1:0] song;
  logic       done_with_note;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       song_done;
  logic [4:0] note_idx;

  song_reader #(
    .NOTES_PER_SONG (32),
    .SONG_SEL_W     (2),
    .ROM_INIT       (TB_IMG)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .done_with_note   (done_with_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done),
    .note_idx         (note_idx)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [11:0] rom_m [N_ENT];
  logic [N_ENT*12-1:0] img_v;
  int          m_song;
  int          m_idx;
  bit          m_ended;
  int          m_end_lat;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_window(input int cycles, output int lc, output int dc);
    lc = 0;
    dc = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      lc += int'(load_new_note);
      dc += int'(song_done);
    end
  endtask

  task automatic wait_event(input int max, output int n, output logic l, output logic d);
    n = 0;
    l = 1'b0;
    d = 1'b0;
    while (n < max && !l && !d) begin
      tick();
      done_with_note = 1'b0;
      n++;
      l = load_new_note;
      d = song_done;
    end
  endtask

  task automatic check_load(input string tag, input int n, input int lat);
    int a;
    a = m_song * 32 + m_idx;
    chk({tag, "_lat"},  n, lat);
    chk({tag, "_load"}, int'(load_new_note), 1);
    chk({tag, "_done"}, int'(song_done), 0);
    chk({tag, "_note"}, int'(note_to_load), int'(rom_m[a][11:6]));
    chk({tag, "_dur"},  int'(duration_to_load), int'(rom_m[a][5:0]));
    chk({tag, "_idx"},  int'(note_idx), m_idx);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_note"}, int'(note_to_load), 0);
    chk({tag, "_dur"},  int'(duration_to_load), 0);
    chk({tag, "_load"}, int'(load_new_note), 0);
    chk({tag, "_done"}, int'(song_done), 0);
    chk({tag, "_idx"},  int'(note_idx), 0);
  endtask

  // Finish the current note (optionally across a pause) and check what follows.
  task automatic finish_note(input bit pause);
    int   n, lc, dc, nxt;
    logic l, d;
    idle_window($urandom_range(1, 5), lc, dc);
    chk("hold_noload", lc + dc, 0);
    if (pause) begin
      play = 1'b0;
      idle_window($urandom_range(0, 3), lc, dc);
      done_with_note = 1'b1;
      tick();
      done_with_note = 1'b0;
      idle_window($urandom_range(4, 10), lc, dc);
      chk("pause_noload", lc + dc, 0);
      play = 1'b1;
    end else begin
      done_with_note = 1'b1;
    end
    wait_event(20, n, l, d);
    nxt = (m_idx + 1) % 32;
    if (m_idx == 31) begin
      chk("wrap_lat", n, 2);
      chk("wrap_done", int'(d), 1);
      chk("wrap_noload", int'(l), 0);
      m_idx     = 0;
      m_ended   = 1'b1;
      m_end_lat = 3;
      chk("wrap_idx", int'(note_idx), 0);
    end else if (rom_m[m_song*32 + nxt][5:0] == 6'd0) begin
      chk("mark_lat", n, 4);
      chk("mark_done", int'(d), 1);
      chk("mark_noload", int'(l), 0);
      m_idx     = nxt;
      m_ended   = 1'b1;
      m_end_lat = 4;
    end else begin
      m_idx = nxt;
      check_load("next", n, 4);
    end
  endtask

  task automatic handle_end();
    int   n, lc, dc;
    logic l, d;
    tick();
    chk("done_single", int'(song_done), 0);
`ifdef SONG_READER_LOOP_EN
    wait_event(12, n, l, d);
    m_idx = 0;
    check_load("loop", n, m_end_lat - 1);
`else
    idle_window($urandom_range(5, 12), lc, dc);
    chk("end_hold", lc + dc, 0);
    play = 1'b0;
    tick();
    chk("end_idx0", int'(note_idx), 0);
    m_idx = 0;
    play = 1'b1;
    wait_event(12, n, l, d);
    check_load("replay", n, 3);
`endif
    m_ended = 1'b0;
  endtask

  initial begin
    int   n, lc, dc;
    logic l, d;
    img_v = TB_IMG;
    for (int i = 0; i < N_ENT; i++) rom_m[i] = img_v[i*12 +: 12];

    reset = 1'b1;
    play = 1'b0;
    song = 2'd0;
    done_with_note = 1'b0;
    m_song = 0;
    m_idx = 0;
    m_ended = 1'b0;
    m_end_lat = 0;
    repeat (2) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // First load from IDLE, then a note end arriving during LOAD is ignored.
    play = 1'b1;
    wait_event(10, n, l, d);
    check_load("first", n, 3);
    done_with_note = 1'b1;
    tick();
    done_with_note = 1'b0;
    idle_window(12, lc, dc);
    chk("first_noload", lc + dc, 0);

    // Whole of song 0, including a forced pause on the second note.
    for (int k = 0; k < 32; k++) finish_note((k == 1) || ($urandom_range(0, 3) == 0));
    chk("song0_ended", int'(m_ended), 1);
    handle_end();

    // Song 1 stops on its end marker at entry 3.
    idle_window(2, lc, dc);
    song = 2'd1;
    m_song = 1;
    m_idx = 0;
    wait_event(10, n, l, d);
    check_load("sel1", n, 3);
    for (int k = 0; k < 3; k++) finish_note($urandom_range(0, 3) == 0);
    chk("song1_ended", int'(m_ended), 1);
    chk("song1_idx", int'(note_idx), 3);
    handle_end();

    // Song 2 up to entry 7, then switch to song 3 mid-note.
    idle_window(2, lc, dc);
    song = 2'd2;
    m_song = 2;
    m_idx = 0;
    wait_event(10, n, l, d);
    check_load("sel2", n, 3);
    for (int k = 0; k < 7; k++) finish_note($urandom_range(0, 3) == 0);
    idle_window(2, lc, dc);
    song = 2'd3;
    m_song = 3;
    m_idx = 0;
    wait_event(10, n, l, d);
    check_load("sel3", n, 3);
    for (int k = 0; k < 2; k++) finish_note($urandom_range(0, 3) == 0);

    // Reset while the next entry is being fetched.
    idle_window(2, lc, dc);
    done_with_note = 1'b1;
    tick();
    done_with_note = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    m_idx = 0;
    wait_event(10, n, l, d);
    check_load("after_rst", n, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
